pc_gen: RTL and testbench

Parametrised program-counter generator for the fetch stage of the MIPS pipeline. It holds the fetch PC and updates it every enabled cycle from a fixed-priority next-PC select: exception vector, ERET return, return-address prediction, branch/jump redirect, or sequential increment. An optional return-address stack (RAS) predicts JR $ra targets. It replaces the earlier single-width, enable-only PC register.

---
 rtl/pc_gen.sv | 164 ++++++++++++++++
 tb/tb_pc_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage program-counter generator with optional return-address stack
//
// Optional feature macro: PC_RAS_EN (builds the return-address stack).
//
// Parameters
//   WIDTH      PC width in bits (>= 8)
//   INC        sequential increment in bytes
//   RESET_VEC  PC after reset, truncated to WIDTH
//   EXC_VEC    exception entry address, truncated to WIDTH
//   RAS_DEPTH  RAS entries, power of 2, >= 2 (PC_RAS_EN only)
//
// Ports
//   clk, reset_n           clock, asynchronous active-low reset
//   en                     advance enable (0 = stall)
//   br_valid, br_target    taken branch/jump redirect
//   exc_valid              exception entry (ignores en)
//   eret_valid, epc        exception return (ignores en)
//   call_valid, link_addr  push a return address onto the RAS
//   ret_valid              JR $ra: pop the RAS and predict its target
//   pc                     registered fetch PC
//   pc_inc                 pc + INC, wraps modulo 2^WIDTH
//   misalign               pc[1:0] != 0
//   ras_empty, ras_full    RAS occupancy flags from the registered count

module pc_gen #(
    parameter int          WIDTH     = 32,
    parameter int          INC       = 4,
    parameter logic [31:0] RESET_VEC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
    parameter int          RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             br_valid,
    input  logic [WIDTH-1:0] br_target,
    input  logic             exc_valid,
    input  logic             eret_valid,
    input  logic [WIDTH-1:0] epc,
    input  logic             call_valid,
    input  logic [WIDTH-1:0] link_addr,
    input  logic             ret_valid,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_inc,
    output logic             misalign,
    output logic             ras_empty,
    output logic             ras_full
);

    localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VEC);
    localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VEC);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;

    assign pc       = pc_q;
    assign pc_inc   = pc_q + WIDTH'(INC);
    assign misalign = |pc_q[1:0];

`ifdef PC_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);

    // Circular buffer: top_q indexes the most recent entry. A push advances
    // top first, so a push while full lands on the oldest entry and
    // overwrites it without any extra bookkeeping.
    logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_mem_d [RAS_DEPTH];
    logic [PW-1:0]    top_q;
    logic [PW-1:0]    top_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic             ras_act;

    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CW'(RAS_DEPTH));

    always_comb begin
        pc_d      = pc_q;
        top_d     = top_q;
        cnt_d     = cnt_q;
        ras_mem_d = ras_mem_q;
        ras_act   = en && !exc_valid && !eret_valid;

        if (exc_valid) begin
            pc_d = EXC_PC;
        end else if (eret_valid) begin
            pc_d = epc;
        end else if (!en) begin
            pc_d = pc_q;
        end else if (ret_valid && !ras_empty) begin
            pc_d = ras_mem_q[top_q];
        end else if (ret_valid || br_valid) begin
            pc_d = br_target;
        end else begin
            pc_d = pc_inc;
        end

        if (ras_act) begin
            if (call_valid && ret_valid && !ras_empty) begin
                // Pop then push: the top slot is simply replaced.
                ras_mem_d[top_q] = link_addr;
            end else if (call_valid) begin
                top_d            = top_q + PW'(1);
                ras_mem_d[top_d] = link_addr;
                if (!ras_full) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else if (ret_valid && !ras_empty) begin
                top_d = top_q - PW'(1);
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q  <= RST_PC;
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry contents are don't-care after reset, so the storage has no reset.
    always_ff @(posedge clk) begin
        ras_mem_q <= ras_mem_d;
    end
`else
    logic unused_ras;

    assign ras_empty  = 1'b1;
    assign ras_full   = 1'b0;
    assign unused_ras = ^{call_valid, link_addr, 32'(RAS_DEPTH)};

    always_comb begin
        pc_d = pc_q;
        if (exc_valid) begin
            pc_d = EXC_PC;
        end else if (eret_valid) begin
            pc_d = epc;
        end else if (!en) begin
            pc_d = pc_q;
        end else if (ret_valid || br_valid) begin
            // Without a RAS a return is just an ordinary redirect.
            pc_d = br_target;
        end else begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= RST_PC;
        end else begin
            pc_q <= pc_d;
        end
    end
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - self-checking bench for pc_gen against a queue-based reference model
module tb_pc_gen;

    localparam int RAS_DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = '0;
    logic        exc_valid = 1'b0;
    logic        eret_valid = 1'b0;
    logic [31:0] epc = '0;
    logic        call_valid = 1'b0;
    logic [31:0] link_addr = '0;
    logic        ret_valid = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_inc;
    logic        misalign;
    logic        ras_empty;
    logic        ras_full;

    logic        en8 = 1'b0;
    logic [7:0]  pc8;
    logic [7:0]  pc_inc8;
    logic        misalign8;
    logic        ras_empty8;
    logic        ras_full8;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    bit cmp_on   = 1'b0;

    always #5 clk = ~clk;

    pc_gen #(.WIDTH(32), .INC(4), .RESET_VEC(32'h0000_3000), .EXC_VEC(32'h0000_4180),
             .RAS_DEPTH(RAS_DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .br_valid(br_valid), .br_target(br_target),
        .exc_valid(exc_valid), .eret_valid(eret_valid), .epc(epc), .call_valid(call_valid),
        .link_addr(link_addr), .ret_valid(ret_valid), .pc(pc), .pc_inc(pc_inc),
        .misalign(misalign), .ras_empty(ras_empty), .ras_full(ras_full)
    );

    pc_gen #(.WIDTH(8), .INC(4), .RESET_VEC(32'h0000_30F4), .EXC_VEC(32'h0000_4180),
             .RAS_DEPTH(2)) dut8 (
        .clk(clk), .reset_n(reset_n), .en(en8), .br_valid(1'b0), .br_target(8'h00),
        .exc_valid(1'b0), .eret_valid(1'b0), .epc(8'h00), .call_valid(1'b0),
        .link_addr(8'h00), .ret_valid(1'b0), .pc(pc8), .pc_inc(pc_inc8),
        .misalign(misalign8), .ras_empty(ras_empty8), .ras_full(ras_full8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: the stack is a plain queue, oldest at the front.
    logic [31:0] m_pc;
    logic [31:0] m_stk[$];

    always @(posedge clk or negedge reset_n) begin
        logic [31:0] nxt;
        if (!reset_n) begin
            m_pc = 32'h0000_3000;
            m_stk.delete();
        end else begin
            nxt = m_pc + 32'd4;
            if (exc_valid) nxt = 32'h0000_4180;
            else if (eret_valid) nxt = epc;
            else if (!en) nxt = m_pc;
            else begin
`ifdef PC_RAS_EN
                if (ret_valid && m_stk.size() > 0) nxt = m_stk[m_stk.size()-1];
                else if (ret_valid || br_valid) nxt = br_target;
                if (call_valid && ret_valid && m_stk.size() > 0) begin
                    m_stk[m_stk.size()-1] = link_addr;
                end else if (call_valid) begin
                    if (m_stk.size() == RAS_DEPTH) void'(m_stk.pop_front());
                    m_stk.push_back(link_addr);
                end else if (ret_valid && m_stk.size() > 0) begin
                    void'(m_stk.pop_back());
                end
`else
                if (ret_valid || br_valid) nxt = br_target;
`endif
            end
            m_pc = nxt;
        end
    end

    // Compare process: outputs depend only on registered state.
    always @(negedge clk) begin
        if (cmp_on) begin
            check("model_pc", pc, m_pc);
            check("model_pc_inc", pc_inc, m_pc + 32'd4);
            check("model_misalign", {31'd0, misalign}, {31'd0, m_pc[1:0] != 2'b00});
`ifdef PC_RAS_EN
            check("model_ras_empty", {31'd0, ras_empty}, {31'd0, m_stk.size() == 0});
            check("model_ras_full", {31'd0, ras_full}, {31'd0, m_stk.size() == RAS_DEPTH});
`else
            check("model_ras_empty", {31'd0, ras_empty}, 32'd1);
            check("model_ras_full", {31'd0, ras_full}, 32'd0);
`endif
        end
    end

    task automatic clr();
        br_valid = 0; exc_valid = 0; eret_valid = 0; call_valid = 0; ret_valid = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_pc", pc, 32'h3000);
        check("rst_pc_inc", pc_inc, 32'h3004);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        check("rst_ras_empty", {31'd0, ras_empty}, 32'd1);
        check("rst_ras_full", {31'd0, ras_full}, 32'd0);
        check("rst_pc8", {24'd0, pc8}, 32'hF4);
        cmp_on = 1;
        reset_n = 1; en = 1;

        // Sequential fetch
        tick(); check("seq1", pc, 32'h3004);
        tick(); check("seq2", pc, 32'h3008);
        tick(); check("seq3", pc, 32'h300C);
        check("seq_misalign", {31'd0, misalign}, 32'd0);

        // Stall, then exception and ERET through a stall
        en = 0;
        tick(); check("stall1", pc, 32'h300C);
        tick(); check("stall2", pc, 32'h300C);
        exc_valid = 1;
        tick(); check("exc_in_stall", pc, 32'h4180);
        clr(); eret_valid = 1; epc = 32'h3010;
        tick(); check("eret", pc, 32'h3010);

        // Priority
        clr(); en = 1;
        exc_valid = 1; eret_valid = 1; br_valid = 1; br_target = 32'h5000;
        tick(); check("prio_exc", pc, 32'h4180);
        clr(); eret_valid = 1; br_valid = 1; epc = 32'h3020;
        tick(); check("prio_eret", pc, 32'h3020);
        clr();

`ifdef PC_RAS_EN
        for (int i = 1; i <= 4; i++) begin
            call_valid = 1; link_addr = 32'(i) << 8;
            tick();
        end
        check("ras_full4", {31'd0, ras_full}, 32'd1);
        link_addr = 32'h500;
        tick(); check("ras_full5", {31'd0, ras_full}, 32'd1);
        clr(); ret_valid = 1; br_target = 32'h0;
        tick(); check("pop1", pc, 32'h500);
        tick(); check("pop2", pc, 32'h400);
        tick(); check("pop3", pc, 32'h300);
        tick(); check("pop4", pc, 32'h200);
        check("pop_empty", {31'd0, ras_empty}, 32'd1);
        br_target = 32'h900;
        tick(); check("pop5_target", pc, 32'h900);
        check("pop5_empty", {31'd0, ras_empty}, 32'd1);
        clr(); call_valid = 1; link_addr = 32'h200;
        tick();
        ret_valid = 1; link_addr = 32'h700;
        tick(); check("pushpop_target", pc, 32'h200);
        check("pushpop_empty", {31'd0, ras_empty}, 32'd0);
        check("pushpop_full", {31'd0, ras_full}, 32'd0);
        clr(); ret_valid = 1;
        tick(); check("pushpop_next", pc, 32'h700);
        check("pushpop_next_empty", {31'd0, ras_empty}, 32'd1);
`else
        ret_valid = 1; br_target = 32'h900;
        tick(); check("ret_as_br", pc, 32'h900);
        clr(); call_valid = 1; link_addr = 32'h200;
        tick();
        clr(); ret_valid = 1; br_target = 32'hA00;
        tick(); check("call_ignored", pc, 32'hA00);
        check("noras_empty", {31'd0, ras_empty}, 32'd1);
`endif

        // Misaligned redirect is reported, not corrected
        clr(); br_valid = 1; br_target = 32'h3002;
        tick(); check("misalign_pc", pc, 32'h3002);
        check("misalign_flag", {31'd0, misalign}, 32'd1);
        check("misalign_inc", pc_inc, 32'h3006);
        clr();

        // 8-bit wrap-around
        en8 = 1;
        tick(); check("w8_f8", {24'd0, pc8}, 32'hF8);
        tick(); check("w8_fc", {24'd0, pc8}, 32'hFC);
        check("w8_inc_wrap", {24'd0, pc_inc8}, 32'h00);
        tick(); check("w8_wrap", {24'd0, pc8}, 32'h00);
        en8 = 0;

        // Randomized run with a mid-run asynchronous reset
        for (int i = 0; i < 1500; i++) begin
            en         = ($urandom % 4) != 0;
            exc_valid  = ($urandom % 32) == 0;
            eret_valid = ($urandom % 32) == 0;
            br_valid   = ($urandom % 4) == 0;
            call_valid = ($urandom % 3) == 0;
            ret_valid  = ($urandom % 3) == 0;
            br_target  = $urandom & (($urandom % 8 == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            epc        = $urandom & 32'hFFFF_FFFC;
            link_addr  = $urandom & 32'hFFFF_FFFC;
            if (i == 700) begin
                @(posedge clk);
                #2 reset_n = 0;
                #1;
                check("midrst_pc", pc, 32'h3000);
                check("midrst_empty", {31'd0, ras_empty}, 32'd1);
                @(negedge clk);
                reset_n = 1;
            end else begin
                tick();
            end
        end

        clr(); en = 0;
        tick();
        cmp_on = 0;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
